// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, fills a 2-entry prefetch queue
// from a combinational instruction memory and shares the port with a debug reader.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_ce,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ack,
    output logic [31:0] dbg_data
);

    typedef enum logic {
        RUN      = 1'b0,
        DBG_RESP = 1'b1
    } state_t;

    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_AFTER_RST  = RESET_PC & PC_ALIGN_MASK;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_q_pc   [2];
    logic [31:0] r_q_inst [2];
    logic [1:0]  r_count;
    logic        r_last_dbg;
    logic [31:0] r_dbg_data;

    logic        w_fetch_wants;
    logic        w_dbg_eligible;
    logic        w_dbg_grant;
    logic        w_fetch_grant;
    logic        w_pop;

    // Grants are gated by rst_n so the memory port is quiet while reset is held.
    always_comb begin
        w_fetch_wants  = !halt && !redirect_valid && (r_count < 2'd2);
        w_dbg_eligible = dbg_req && (r_state == RUN);
        w_dbg_grant    = rst_n && w_dbg_eligible && (!w_fetch_wants || !r_last_dbg);
        w_fetch_grant  = rst_n && !w_dbg_grant && w_fetch_wants;
        w_pop          = (r_count != 2'd0) && inst_ready;
    end

    always_comb begin
        imem_ce   = 1'b0;
        imem_addr = '0;
        if (w_dbg_grant) begin
            imem_ce   = 1'b1;
            imem_addr = dbg_addr;
        end else if (w_fetch_grant) begin
            imem_ce   = 1'b1;
            imem_addr = r_fetch_pc;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:      if (w_dbg_grant) w_state_next = DBG_RESP;
            DBG_RESP: w_state_next = RUN;
            default:  w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= PC_AFTER_RST;
            r_last_dbg <= 1'b0;
            r_dbg_data <= '0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc & PC_ALIGN_MASK;
            end else if (w_fetch_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_dbg_grant) begin
                r_last_dbg <= 1'b1;
                r_dbg_data <= imem_data;
            end else if (w_fetch_grant) begin
                r_last_dbg <= 1'b0;
            end
        end
    end

    // Head always lives in slot 0; a pop shifts slot 1 down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_q_pc[0]   <= '0;
            r_q_pc[1]   <= '0;
            r_q_inst[0] <= '0;
            r_q_inst[1] <= '0;
        end else if (redirect_valid) begin
            r_count     <= '0;
            r_q_pc[0]   <= '0;
            r_q_pc[1]   <= '0;
            r_q_inst[0] <= '0;
            r_q_inst[1] <= '0;
        end else begin
            case ({w_fetch_grant, w_pop})
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_q_pc[0]   <= r_fetch_pc;
                        r_q_inst[0] <= imem_data;
                    end else begin
                        r_q_pc[0]   <= r_q_pc[1];
                        r_q_inst[0] <= r_q_inst[1];
                        r_q_pc[1]   <= r_fetch_pc;
                        r_q_inst[1] <= imem_data;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_q_pc[0]   <= r_fetch_pc;
                        r_q_inst[0] <= imem_data;
                    end else begin
                        r_q_pc[1]   <= r_fetch_pc;
                        r_q_inst[1] <= imem_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_q_pc[0]   <= r_q_pc[1];
                    r_q_inst[0] <= r_q_inst[1];
                    r_count     <= r_count - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        inst_valid = (r_count != 2'd0);
        inst_data  = inst_valid ? r_q_inst[0] : '0;
        inst_pc    = inst_valid ? r_q_pc[0]   : '0;
        dbg_ack    = (r_state == DBG_RESP);
        dbg_data   = r_dbg_data;
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: table-driven cycle vectors for reset/streaming/backpressure,
// then hand sequences for redirect, debug arbitration, halt and mid-operation reset.
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_ce;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;

    logic [31:0] mem [1024];

    int checks;
    int failures;
    logic sb_on;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_exp_t;

    inst_exp_t   inst_q [$];
    logic [31:0] dbg_q  [$];

    typedef struct {
        logic        rst;
        logic        ready;
        logic        exp_ce;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [16];

    ifetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_ce        (imem_ce),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_ack        (dbg_ack),
        .dbg_data       (dbg_data)
    );

    assign imem_data = mem[imem_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic monitor();
        inst_exp_t e;
        logic [31:0] d;
        if (sb_on && inst_valid && inst_ready) begin
            if (inst_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL inst_unexpected: actual pc=%h required=no delivery", inst_pc);
            end else begin
                e = inst_q.pop_front();
                check32("sb_inst_pc", inst_pc, e.pc);
                check32("sb_inst_data", inst_data, e.data);
            end
        end
        if (dbg_ack) begin
            if (dbg_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dbg_unexpected_ack: actual data=%h required=no ack", dbg_data);
            end else begin
                d = dbg_q.pop_front();
                check32("sb_dbg_data", dbg_data, d);
            end
        end
    endtask

    task automatic next_cycle();
        monitor();
        @(negedge clk);
    endtask

    task automatic push_inst(input logic [31:0] pc);
        inst_exp_t e;
        e.pc   = pc;
        e.data = mem[pc[11:2]];
        inst_q.push_back(e);
    endtask

    initial begin
        logic [31:0] exp_a;
        checks   = 0;
        failures = 0;
        sb_on    = 1'b0;
        for (int unsigned i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
        mem[0] = 32'h0000_f025;
        mem[1] = 32'h241d_1000;
        mem[2] = 32'h8f99_0068;
        mem[3] = 32'h0411_00e6;

        //           rst   rdy   ce    addr          valid pc            data
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_f025};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h241d_1000};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h8f99_0068};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 32'h0411_00e6};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_f025};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_f025};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_f025};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_f025};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_f025};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h241d_1000};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h8f99_0068};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 32'h0411_00e6};

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        inst_ready     = 1'b1;
        dbg_req        = 1'b0;
        dbg_addr       = '0;
        @(negedge clk);

        for (int unsigned i = 0; i < 16; i++) begin
            rst_n      = !vecs[i].rst;
            inst_ready = vecs[i].ready;
            settle();
            check32($sformatf("vec%0d_ce", i),    {31'd0, imem_ce},    {31'd0, vecs[i].exp_ce});
            check32($sformatf("vec%0d_addr", i),  imem_addr,           vecs[i].exp_addr);
            check32($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_valid});
            check32($sformatf("vec%0d_pc", i),    inst_pc,             vecs[i].exp_pc);
            check32($sformatf("vec%0d_data", i),  inst_data,           vecs[i].exp_data);
            check32($sformatf("vec%0d_ack", i),   {31'd0, dbg_ack},    32'd0);
            if (vecs[i].rst) check32($sformatf("vec%0d_dbgdata", i), dbg_data, 32'd0);
            next_cycle();
        end

        // Redirect while full with a same-cycle pop.
        sb_on = 1'b1;
        push_inst(32'h0000_000C);
        for (int unsigned k = 0; k < 8; k++) push_inst(32'h0000_00B0 + 32'(4 * k));
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_00B3;
        settle();
        check32("redir_ce", {31'd0, imem_ce}, 32'd0);
        check32("redir_pop_pc", inst_pc, 32'h0000_000C);
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        check32("redir_n1_valid", {31'd0, inst_valid}, 32'd0);
        check32("redir_n1_addr", imem_addr, 32'h0000_00B0);
        next_cycle();
        settle();
        check32("redir_n2_pc", inst_pc, 32'h0000_00B0);
        check32("redir_n2_data", inst_data, 32'hC0DE_002C);
        next_cycle();
        for (int unsigned k = 0; k < 3; k++) begin
            settle();
            next_cycle();
        end

        // Continuous debug contention against free-running fetch.
        for (int unsigned k = 0; k < 3; k++) dbg_q.push_back(mem[7]);
        dbg_req  = 1'b1;
        dbg_addr = 32'h0000_001C;
        for (int unsigned i = 0; i < 6; i++) begin
            settle();
            exp_a = (i % 2 == 0) ? 32'h0000_001C : 32'h0000_00C4 + 32'(4 * (i / 2));
            check32($sformatf("arb%0d_addr", i), imem_addr, exp_a);
            check32($sformatf("arb%0d_ack", i), {31'd0, dbg_ack}, 32'(i % 2));
            next_cycle();
        end
        dbg_req = 1'b0;
        settle();
        next_cycle();
        inst_ready = 1'b0;
        settle();
        check32("arb_inst_q_empty", 32'(inst_q.size()), 32'd0);
        check32("arb_dbg_q_empty", 32'(dbg_q.size()), 32'd0);
        next_cycle();

        // Halt with a full queue: drain, serve debug, then resume.
        push_inst(32'h0000_00D0);
        push_inst(32'h0000_00D4);
        halt = 1'b1;
        settle();
        check32("halt0_ce", {31'd0, imem_ce}, 32'd0);
        check32("halt0_pc", inst_pc, 32'h0000_00D0);
        next_cycle();
        inst_ready = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            settle();
            check32($sformatf("halt_drain%0d_ce", i), {31'd0, imem_ce}, 32'd0);
            next_cycle();
        end
        dbg_q.push_back(mem[16]);
        dbg_req  = 1'b1;
        dbg_addr = 32'h0000_0040;
        settle();
        check32("halt_dbg_valid", {31'd0, inst_valid}, 32'd0);
        check32("halt_dbg_addr", imem_addr, 32'h0000_0040);
        next_cycle();
        settle();
        check32("halt_dbg_ack", {31'd0, dbg_ack}, 32'd1);
        check32("halt_resp_ce", {31'd0, imem_ce}, 32'd0);
        next_cycle();
        dbg_req = 1'b0;
        halt    = 1'b0;
        settle();
        check32("resume_addr", imem_addr, 32'h0000_00D8);
        check32("halt_q_empty", 32'(inst_q.size()), 32'd0);
        next_cycle();

        // Reset while a debug response is pending and count=1.
        inst_ready = 1'b0;
        dbg_req    = 1'b1;
        dbg_addr   = 32'h0000_0020;
        dbg_q.push_back(mem[8]);
        settle();
        check32("pre_rst_pc", inst_pc, 32'h0000_00D8);
        check32("pre_rst_data", inst_data, 32'hC0DE_0036);
        check32("pre_rst_addr", imem_addr, 32'h0000_0020);
        next_cycle();
        settle();
        check32("dbgresp_ack", {31'd0, dbg_ack}, 32'd1);
        check32("dbgresp_valid", {31'd0, inst_valid}, 32'd1);
        monitor();
        sb_on = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check32("rst_ce", {31'd0, imem_ce}, 32'd0);
        check32("rst_addr", imem_addr, 32'd0);
        check32("rst_valid", {31'd0, inst_valid}, 32'd0);
        check32("rst_pc", inst_pc, 32'd0);
        check32("rst_data", inst_data, 32'd0);
        check32("rst_ack", {31'd0, dbg_ack}, 32'd0);
        check32("rst_dbgdata", dbg_data, 32'd0);
        @(negedge clk);
        settle();
        next_cycle();
        rst_n      = 1'b1;
        dbg_req    = 1'b0;
        inst_ready = 1'b1;
        settle();
        check32("post_rst_addr", imem_addr, 32'h0000_0000);
        check32("post_rst_ce", {31'd0, imem_ce}, 32'd1);
        next_cycle();
        settle();
        check32("post_rst_pc", inst_pc, 32'h0000_0000);
        check32("post_rst_data", inst_data, 32'h0000_f025);
        for (int unsigned i = 0; i < 4; i++) begin
            check32($sformatf("post_rst_noack%0d", i), {31'd0, dbg_ack}, 32'd0);
            next_cycle();
            settle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller and port arbiter for the 4 KB combinational instruction memory. It owns the fetch PC and issues one word read per cycle into a 2-entry prefetch queue. It presents instructions to decode over a valid/ready handshake, handles branch/jump/exception redirects with a queue flush, and shares the memory port with a debug/loader read port under alternating-priority arbitration.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset. Bits [1:0] are ignored.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_ce` out 1: memory chip enable.
- `imem_addr` out 32: byte address to memory.
- `imem_data` in 32: memory read data, combinational in the same cycle.
- `redirect_valid` in 1: single-cycle redirect request.
- `redirect_pc` in 32: redirect target.
- `halt` in 1: level; suppresses new fetches while high.
- `inst_valid` out 1: queue head is valid.
- `inst_ready` in 1: decode accepts the head.
- `inst_data` out 32: head instruction word.
- `inst_pc` out 32: head instruction address.
- `dbg_req` in 1: debug read request; held until `dbg_ack`.
- `dbg_addr` in 32: debug byte address.
- `dbg_ack` out 1: one-cycle pulse; `dbg_data` is valid in this cycle.
- `dbg_data` out 32: registered debug read data.

## Operation
- Registers:
  - `fetch_pc` resets to `{RESET_PC[31:2],2'b00}`.
  - 2-entry queue of {pc, inst} with a 2-bit `count`.
  - `last_dbg` flag.
  - state ∈ {RUN, DBG_RESP}.
- fetch_wants = !halt && !redirect_valid && count<2.
- dbg_eligible = dbg_req && state==RUN.
- Grant rules, evaluated each cycle:
  - dbg_eligible && (!fetch_wants || !last_dbg) → debug grant: `imem_ce`=1, `imem_addr`=dbg_addr; `dbg_data`<=imem_data; state<=DBG_RESP; last_dbg<=1.
  - Otherwise, fetch_wants → fetch grant: `imem_ce`=1, `imem_addr`=fetch_pc; push {fetch_pc, imem_data}; fetch_pc<=fetch_pc+4 (32-bit wrap); last_dbg<=0.
  - Neither → `imem_ce`=0, `imem_addr`=0.
- DBG_RESP: `dbg_ack`=1 for exactly one cycle, then state returns to RUN. `dbg_req` is ignored while in DBG_RESP.
- Pop: inst_valid && inst_ready removes the head. Push and pop may occur in the same cycle; `count` is then unchanged.
- Redirect (priority over fetch):
  - The queue is cleared at the edge, overriding any same-cycle push.
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - A pop in the redirect cycle still counts as accepted by decode.
  - A debug grant may occur in the redirect cycle.
- Halt: fetch stops; queued entries still drain; debug is still served. Deasserting halt resumes from the current `fetch_pc`.
- `inst_valid` = count!=0. `inst_data` and `inst_pc` come from head storage; both are 0 when the queue is empty.
- Under continuous contention, debug and fetch grants alternate. A debug request with no competing fetch is granted immediately.

## Timing
- Reset values: `imem_ce`=0, `imem_addr`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `dbg_ack`=0, `dbg_data`=0, count=0, last_dbg=0, state=RUN.
- `imem_ce` and `imem_addr` are combinational from state and inputs. `inst_*` and `dbg_*` are registered.
- Fetch latency:
  - Fetch granted in cycle N → `inst_valid` in N+1.
  - First fetch after reset release occurs in the first clocked cycle.
- Throughput: 1 instruction/cycle when `inst_ready` is held high. Steady-state count=1.
- Redirect latency: redirect in cycle N → target fetched in N+1 → `inst_valid` with inst_pc=target in N+2. `inst_valid` is 0 in N+1.
- Debug latency: granted in N → `dbg_ack` in N+1. The earliest next debug grant is N+2.
- Full queue (count=2, no pop): no fetch; `fetch_pc` holds.
- Reset mid-operation: all state clears immediately. A pending debug request is dropped and `dbg_ack` is never issued; the requester re-requests.

## Test plan
- Reset, `inst_ready`=1, memory words 0..3 = 0x0000f025, 0x241d1000, 0x8f990068, 0x041100e6 → `inst_valid` rises at cycle 1. Cycles 1–4 show inst_pc 0,4,8,C with the matching data, one per cycle.
- `inst_ready`=0 for 5 cycles → exactly 2 fetches (addr 0, 4), then `imem_ce`=0 and `fetch_pc`=8. Releasing `inst_ready` delivers 0, 4, 8 with no gap or duplicate.
- Redirect to 0x0000_00B3 while count=2 and a pop is in the same cycle → queue flushed, next `inst_pc`=0xB0 two cycles later. No stale entries appear.
- `dbg_req` held high with `dbg_addr`=0x1C while fetch runs freely → grants alternate debug/fetch; `dbg_ack` pulses one cycle after each debug grant with `dbg_data`=mem[7].
- `halt`=1 with count=2 → queue drains, no further `imem_ce` for fetch. A debug read during halt still acks. Deasserting halt resumes at the correct next PC.
- Assert `rst_n` low during DBG_RESP and with count=1 → all outputs go to 0 immediately. After release, fetch restarts at `RESET_PC` and no `dbg_ack` is issued.
